// File: rtl/pe_pkg.sv
// Shared types and the fixed-point clamp helper for the dual-mode systolic PE.
package pe_pkg;

   typedef enum logic {PE_MODE_WS = 1'b0, PE_MODE_OS = 1'b1} pe_mode_e;

   localparam int FXP_W = 64;

   typedef struct packed {
      logic                    ovf;
      logic signed [FXP_W-1:0] val;
   } fxp_sat_t;

   // Clamp a wide signed value into a dw-bit signed range and flag out-of-range inputs.
   function automatic fxp_sat_t fxp_sat(input logic signed [FXP_W-1:0] value, input int dw);
      logic signed [FXP_W-1:0] hi;
      logic signed [FXP_W-1:0] lo;
      fxp_sat_t                r;
      hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo    = -(64'sd1 <<< (dw - 1));
      r.ovf = (value > hi) || (value < lo);
      if (value > hi)
         r.val = hi;
      else if (value < lo)
         r.val = lo;
      else
         r.val = value;
      return r;
   endfunction

endpackage

// File: rtl/pe_fxp_mac.sv
// Combinational fixed-point MAC: (a*b)>>>FRAC_BITS + addend, reduced to DATA_WIDTH by clamp or wrap.
module pe_fxp_mac
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int SATURATE   = 1
) (
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   input  logic signed [DATA_WIDTH-1:0] addend,
   output logic signed [DATA_WIDTH-1:0] result,
   output logic                         ovf
);

   logic signed [2*DATA_WIDTH-1:0] prod_full;
   logic signed [2*DATA_WIDTH-1:0] prod_shr;
   logic signed [DATA_WIDTH-1:0]   prod_r;
   logic signed [DATA_WIDTH+1:0]   sum;
   fxp_sat_t                       sat_p;
   fxp_sat_t                       sat_s;
   logic                           unused_hi;

   always_comb begin
      prod_full = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
      prod_shr  = prod_full >>> FRAC_BITS;
      sat_p     = fxp_sat(FXP_W'(prod_shr), DATA_WIDTH);
      prod_r    = (SATURATE != 0) ? sat_p.val[DATA_WIDTH-1:0] : prod_shr[DATA_WIDTH-1:0];
      // Two guard bits are enough: both addends already fit in DATA_WIDTH.
      sum       = (DATA_WIDTH+2)'(prod_r) + (DATA_WIDTH+2)'(addend);
      sat_s     = fxp_sat(FXP_W'(sum), DATA_WIDTH);
      result    = (SATURATE != 0) ? sat_s.val[DATA_WIDTH-1:0] : sum[DATA_WIDTH-1:0];
      ovf       = sat_p.ovf | sat_s.ovf;
   end

   assign unused_hi = ^{sat_p.val[FXP_W-1:DATA_WIDTH], sat_s.val[FXP_W-1:DATA_WIDTH]};

endmodule

// File: rtl/pe_fxp_dual.sv
// Systolic PE with double-buffered weights; weight-stationary or output-stationary per cycle.
module pe_fxp_dual
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int SATURATE   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pe_mode_in,
   input  logic [DATA_WIDTH-1:0] pe_psum_in,
   input  logic [DATA_WIDTH-1:0] pe_weight_in,
   input  logic                  pe_accept_w_in,
   input  logic [DATA_WIDTH-1:0] pe_input_in,
   input  logic                  pe_valid_in,
   input  logic                  pe_switch_in,
   input  logic                  pe_drain_in,
   input  logic                  pe_ovf_clr_in,
   output logic [DATA_WIDTH-1:0] pe_psum_out,
   output logic                  pe_psum_valid_out,
   output logic [DATA_WIDTH-1:0] pe_weight_out,
   output logic                  pe_accept_w_out,
   output logic [DATA_WIDTH-1:0] pe_input_out,
   output logic                  pe_valid_out,
   output logic                  pe_switch_out,
   output logic                  pe_drain_out,
   output logic                  pe_overflow_out
);

   pe_mode_e                     mode_cur;
   pe_mode_e                     mode_prev;
   logic                         os_mode;
   logic                         mode_chg;
   logic signed [DATA_WIDTH-1:0] w_active;
   logic signed [DATA_WIDTH-1:0] w_inactive;
   logic signed [DATA_WIDTH-1:0] acc;
   logic signed [DATA_WIDTH-1:0] acc_base;
   logic signed [DATA_WIDTH-1:0] mac_b;
   logic signed [DATA_WIDTH-1:0] mac_add;
   logic signed [DATA_WIDTH-1:0] mac_res;
   logic                         mac_ovf;

   logic signed [DATA_WIDTH-1:0] psum_p1;
   logic                         vld_p1;
   logic [DATA_WIDTH-1:0]        weight_p1;
   logic                         accept_p1;
   logic [DATA_WIDTH-1:0]        input_p1;
   logic                         in_vld_p1;
   logic                         switch_p1;
   logic                         drain_p1;
   logic                         ovf_p1;

   // Stage p0: operand selection; a mode change zeroes the accumulator this same cycle.
   always_comb begin
      mode_cur = pe_mode_e'(pe_mode_in);
      os_mode  = (mode_cur == PE_MODE_OS);
      mode_chg = (mode_cur != mode_prev);
      acc_base = mode_chg ? '0 : acc;
      mac_b    = os_mode ? pe_weight_in : w_active;
      mac_add  = os_mode ? (pe_drain_in ? '0 : acc_base) : pe_psum_in;
   end

   pe_fxp_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .SATURATE   (SATURATE)
   ) u_mac (
      .a      (pe_input_in),
      .b      (mac_b),
      .addend (mac_add),
      .result (mac_res),
      .ovf    (mac_ovf)
   );

   // Stage p1: state update and registered south/east outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_prev  <= PE_MODE_WS;
         w_active   <= '0;
         w_inactive <= '0;
         acc        <= '0;
         psum_p1    <= '0;
         vld_p1     <= 1'b0;
         weight_p1  <= '0;
         accept_p1  <= 1'b0;
         input_p1   <= '0;
         in_vld_p1  <= 1'b0;
         switch_p1  <= 1'b0;
         drain_p1   <= 1'b0;
         ovf_p1     <= 1'b0;
      end else begin
         mode_prev <= mode_cur;
         if (pe_accept_w_in)
            w_inactive <= pe_weight_in;
         if (pe_switch_in)
            w_active <= w_inactive;
         weight_p1 <= (pe_accept_w_in || (os_mode && pe_valid_in)) ? pe_weight_in : '0;
         accept_p1 <= pe_accept_w_in;
         in_vld_p1 <= pe_valid_in;
         switch_p1 <= pe_switch_in;
         drain_p1  <= pe_drain_in;
         if (pe_valid_in)
            input_p1 <= pe_input_in;
         if (pe_ovf_clr_in)
            ovf_p1 <= 1'b0;
         else if (pe_valid_in && mac_ovf)
            ovf_p1 <= 1'b1;
         if (!os_mode) begin
            psum_p1 <= pe_valid_in ? mac_res : '0;
            vld_p1  <= pe_valid_in;
            acc     <= acc_base;
         end else begin
            psum_p1 <= pe_drain_in ? acc_base : '0;
            vld_p1  <= pe_drain_in;
            if (pe_valid_in)
               acc <= mac_res;
            else if (pe_drain_in)
               acc <= '0;
            else
               acc <= acc_base;
         end
      end
   end

   assign pe_psum_out       = psum_p1;
   assign pe_psum_valid_out = vld_p1;
   assign pe_weight_out     = weight_p1;
   assign pe_accept_w_out   = accept_p1;
   assign pe_input_out      = input_p1;
   assign pe_valid_out      = in_vld_p1;
   assign pe_switch_out     = switch_p1;
   assign pe_drain_out      = drain_p1;
   assign pe_overflow_out   = ovf_p1;

endmodule
